// File: rtl/stream_realign.sv
// Header/payload realigner: passes HDR_BEATS header beats (one 16-bit field optionally patched),
// then shifts the payload down by PAY_OFS bytes so it starts at byte 0, adding a flush beat for leftovers.
// Latency 1 cycle (registered output); s_tready follows the output register, and drops for the flush cycle.
//
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   s_tdata/s_tkeep/s_tlast       input beat; s_tvalid/s_tready handshake
//   m_tdata/m_tkeep/m_tlast       output beat; m_tvalid/m_tready handshake
//   m_is_header                   high while the output beat is a header beat
module stream_realign #(
    parameter int          DATA_W     = 256,
    parameter int          HDR_BEATS  = 4,
    parameter int          PAY_OFS    = 10,
    parameter int          PATCH_EN   = 1,
    parameter int          PATCH_BEAT = 1,
    parameter int          PATCH_LSB  = 96,
    parameter logic [15:0] PATCH_VAL  = 16'h0008
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_W/8-1:0]   m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_is_header
);

    localparam int B  = DATA_W / 8;
    // Bits of a beat that lie above the payload start; this is what carries over as tail.
    localparam int TW = DATA_W - PAY_OFS * 8;
    localparam int NW = $clog2(B + 1);
    localparam int CW = $clog2(HDR_BEATS + 1);

    localparam logic [CW-1:0] LAST_HDR = CW'(HDR_BEATS - 1);
    localparam logic [CW-1:0] PAY_CNT  = CW'(HDR_BEATS);
    localparam logic [CW-1:0] PB       = CW'(PATCH_BEAT);
    localparam logic [NW-1:0] OFS_N    = NW'(PAY_OFS);
    localparam logic [NW-1:0] T_N      = NW'(B - PAY_OFS);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_PAY   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [TW-1:0]   tail, tail_nxt;
    logic [NW-1:0]   tail_n, tail_n_nxt;

    logic            accept;
    logic            load;
    logic [NW-1:0]   n;
    logic [NW-1:0]   new_tail_n;
    logic [TW-1:0]   new_tail;
    logic            captures_tail;

    logic [DATA_W-1:0] beat_data;
    logic [B-1:0]      beat_keep;
    logic              beat_last;
    logic              beat_hdr;
    logic              beat_produce;

    function automatic logic [NW-1:0] popcount(input logic [B-1:0] k);
        logic [NW-1:0] c;
        c = '0;
        for (int j = 0; j < B; j++) begin
            c = c + {{(NW-1){1'b0}}, k[j]};
        end
        return c;
    endfunction

    function automatic logic [B-1:0] low_mask(input logic [NW-1:0] c);
        logic [B-1:0] m;
        m = '0;
        for (int j = 0; j < B; j++) begin
            m[j] = (j < int'(c));
        end
        return m;
    endfunction

    // The output register can take a new beat when it is empty or draining this cycle.
    assign load     = !m_tvalid || m_tready;
    assign s_tready = !reset && (state != ST_FLUSH) && load;
    assign accept   = s_tvalid && s_tready;

    assign n          = popcount(s_tkeep);
    assign new_tail_n = (n > OFS_N) ? (n - OFS_N) : '0;
    assign new_tail   = s_tdata[DATA_W-1 -: TW];

    // The last header beat and every payload beat leave bytes behind for the next output beat.
    assign captures_tail = accept &&
                           (((state == ST_HDR) && (cnt == LAST_HDR)) || (state == ST_PAY));

    // State register (plus beat counter and carried tail).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_HDR;
            cnt    <= '0;
            tail   <= '0;
            tail_n <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tail   <= tail_nxt;
            tail_n <= tail_n_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tail_nxt   = tail;
        tail_n_nxt = tail_n;

        if (captures_tail) begin
            tail_nxt   = new_tail;
            tail_n_nxt = new_tail_n;
        end

        case (state)
            ST_HDR: begin
                if (accept) begin
                    if (s_tlast) begin
                        cnt_nxt = '0;
                        // A packet ending on the last header beat can still owe payload bytes.
                        if ((cnt == LAST_HDR) && (new_tail_n != '0)) begin
                            state_nxt = ST_FLUSH;
                        end else begin
                            state_nxt = ST_HDR;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == LAST_HDR) begin
                            state_nxt = ST_PAY;
                        end
                    end
                end
            end
            ST_PAY: begin
                // Counter sits at HDR_BEATS for the rest of the packet, so long packets never wrap.
                cnt_nxt = PAY_CNT;
                if (accept && s_tlast) begin
                    cnt_nxt   = '0;
                    state_nxt = (new_tail_n != '0) ? ST_FLUSH : ST_HDR;
                end
            end
            ST_FLUSH: begin
                cnt_nxt = '0;
                if (load) begin
                    state_nxt = ST_HDR;
                end
            end
            default: begin
                state_nxt = ST_HDR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: the beat presented to the output register this cycle.
    always_comb begin
        beat_data    = s_tdata;
        beat_keep    = s_tkeep;
        beat_last    = 1'b0;
        beat_hdr     = 1'b0;
        beat_produce = accept;

        case (state)
            ST_HDR: begin
                beat_data = s_tdata;
                if ((PATCH_EN != 0) && (cnt == PB)) begin
                    beat_data[PATCH_LSB +: 16] = PATCH_VAL;
                end
                beat_keep = s_tkeep;
                beat_hdr  = 1'b1;
                beat_last = s_tlast && !((cnt == LAST_HDR) && (new_tail_n != '0));
            end
            ST_PAY: begin
                beat_data = {s_tdata[PAY_OFS*8-1:0], tail};
                beat_keep = low_mask(T_N + ((n < OFS_N) ? n : OFS_N));
                beat_hdr  = 1'b0;
                beat_last = s_tlast && (new_tail_n == '0);
            end
            ST_FLUSH: begin
                beat_data          = '0;
                beat_data[TW-1:0]  = tail;
                beat_keep          = low_mask(tail_n);
                beat_hdr           = 1'b0;
                beat_last          = 1'b1;
                beat_produce       = 1'b1;
            end
            default: begin
                beat_produce = 1'b0;
            end
        endcase
    end

    // Registered output stage; contents hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tkeep     <= '0;
            m_tlast     <= 1'b0;
            m_is_header <= 1'b0;
        end else if (load) begin
            m_tvalid <= beat_produce;
            if (beat_produce) begin
                m_tdata     <= beat_data;
                m_tkeep     <= beat_keep;
                m_tlast     <= beat_last;
                m_is_header <= beat_hdr;
            end
        end
    end

endmodule

// File: tb/tb_stream_realign.sv
module tb_stream_realign;

    localparam int DW  = 256;
    localparam int B   = 32;
    localparam int H   = 4;
    localparam int OFS = 10;
    localparam int T   = 22;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   s_tdata = '0;
    logic [B-1:0]    s_tkeep = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            s_tlast = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [B-1:0]    m_tkeep;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic            m_is_header;

    always #5 clk = ~clk;

    stream_realign #(
        .DATA_W(DW), .HDR_BEATS(H), .PAY_OFS(OFS), .PATCH_EN(1),
        .PATCH_BEAT(1), .PATCH_LSB(96), .PATCH_VAL(16'h0008)
    ) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_is_header(m_is_header)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [B-1:0]  keep;
        logic          last;
        logic          hdr;
    } beat_t;

    typedef struct {
        int          nb;
        int          nl;
        int          exp_cnt;
        logic [31:0] exp_lkeep;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[9];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   out_cnt  = 0;
    logic [B-1:0] last_keep_seen = '0;
    logic rand_mode  = 1'b0;
    logic gaps       = 1'b0;
    logic mon_ignore = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [B-1:0] kmask(input int c);
        logic [B-1:0] m;
        m = '0;
        for (int j = 0; j < c; j++) m[j] = 1'b1;
        return m;
    endfunction

    // Output ready: always 1, or a coin flip each cycle.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples at negedge; a valid&ready seen here completes at the next posedge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] sv_data;
    logic [B-1:0]  sv_keep;
    logic          sv_last, sv_hdr;

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_is_header} !==
                        {1'b1, sv_data, sv_keep, sv_last, sv_hdr}) begin
                        n_fail++;
                        $display("FAIL stall_hold: got vld=%b keep=%h last=%b hdr=%b expected vld=1 keep=%h last=%b hdr=%b",
                                 m_tvalid, m_tkeep, m_tlast, m_is_header, sv_keep, sv_last, sv_hdr);
                    end
                end
                if (m_tvalid && m_tready && !mon_ignore) begin
                    out_cnt++;
                    if (m_tlast) last_keep_seen = m_tkeep;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got keep=%h last=%b expected no beat", m_tkeep, m_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_tdata, m_tkeep, m_tlast, m_is_header} !== {e.data, e.keep, e.last, e.hdr}) begin
                            n_fail++;
                            $display("FAIL beat: got data=%h keep=%h last=%b hdr=%b expected data=%h keep=%h last=%b hdr=%b",
                                     m_tdata, m_tkeep, m_tlast, m_is_header, e.data, e.keep, e.last, e.hdr);
                        end
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                sv_data = m_tdata; sv_keep = m_tkeep; sv_last = m_tlast; sv_hdr = m_is_header;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input logic l);
        int   budget;
        logic rdy;
        budget = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            budget++;
        end while (!rdy && budget < 500);
        if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no s_tready in %0d cycles expected acceptance", budget);
        end
        #1;
    endtask

    task automatic send_packet(input int nb, input int nl);
        logic [DW-1:0]  pk[$];
        logic [DW-1:0]  d;
        logic [DW-T*8-1:0] unused_lo;
        logic [T*8-1:0] tl;
        int    tn, n, g;
        logic  fin, flush;
        beat_t e;
        tl = '0; tn = 0;
        for (int i = 0; i < nb; i++) begin
            n = (i == nb - 1) ? nl : B;
            for (int b = 0; b < B; b++) d[b*8 +: 8] = (b < n) ? 8'($urandom) : 8'h00;
            pk.push_back(d);
        end
        // Reference model, written from the packet-level description.
        for (int i = 0; i < nb; i++) begin
            n = (i == nb - 1) ? nl : B;
            fin = (i == nb - 1);
            if (i < H) begin
                e.data = pk[i];
                if (i == 1) e.data[111:96] = 16'h0008;
                e.keep = kmask(n);
                e.hdr  = 1'b1;
                if (i == H - 1) begin
                    tl = pk[i][DW-1:OFS*8];
                    tn = (n > OFS) ? n - OFS : 0;
                end
                e.last = fin && ((i < H - 1) || (tn == 0));
            end else begin
                unused_lo = pk[i][OFS*8-1:0];
                e.data = {unused_lo, tl};
                e.keep = kmask(T + ((n < OFS) ? n : OFS));
                e.hdr  = 1'b0;
                tl = pk[i][DW-1:OFS*8];
                tn = (n > OFS) ? n - OFS : 0;
                e.last = fin && (tn == 0);
            end
            exp_q.push_back(e);
        end
        flush = (nb >= H) && (tn > 0);
        if (flush) begin
            e.data = '0;
            e.data[T*8-1:0] = tl;
            e.keep = kmask(tn);
            e.last = 1'b1;
            e.hdr  = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            if (g > 0) begin
                s_tvalid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            send_beat(pk[i], (i == nb - 1) ? kmask(nl) : kmask(B), i == nb - 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (flush) begin
            @(negedge clk);
            check("flush_tready_low", 64'(s_tready), 64'd0);
            if (!rand_mode) begin
                @(negedge clk);
                check("flush_one_bubble", 64'(s_tready), 64'd1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_tlast"},  64'(m_tlast), 64'd0);
        check({tag, "_hdr"},    64'(m_is_header), 64'd0);
        check({tag, "_tdata"},  64'(|m_tdata), 64'd0);
        check({tag, "_tkeep"},  64'(m_tkeep), 64'd0);
        check({tag, "_tready"}, 64'(s_tready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        logic [DW-1:0] d;
        // {beats, bytes in final beat, expected output beats, expected final keep}
        tbl[0] = '{6,  32, 7,  32'h003FFFFF};
        tbl[1] = '{6,  8,  6,  32'h3FFFFFFF};
        tbl[2] = '{3,  32, 3,  32'hFFFFFFFF};
        tbl[3] = '{4,  32, 5,  32'h003FFFFF};
        tbl[4] = '{4,  10, 4,  32'h000003FF};
        tbl[5] = '{1,  5,  1,  32'h0000001F};
        tbl[6] = '{5,  11, 6,  32'h00000001};
        tbl[7] = '{20, 32, 21, 32'h003FFFFF};
        tbl[8] = '{4,  11, 5,  32'h00000001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed pass: m_tready high, no gaps, one packet at a time.
        for (int r = 0; r < 9; r++) begin
            out_cnt = 0;
            send_packet(tbl[r].nb, tbl[r].nl);
            wait_drain();
            check($sformatf("row%0d_beats", r), 64'(out_cnt), 64'(tbl[r].exp_cnt));
            check($sformatf("row%0d_lastkeep", r), 64'(last_keep_seen), 64'(tbl[r].exp_lkeep));
        end

        // Back-to-back packets with random output stalls and input gaps.
        rand_mode = 1'b1;
        gaps = 1'b1;
        out_cnt = 0;
        total = 0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 9; r++) begin
                send_packet(tbl[r].nb, tbl[r].nl);
                total += tbl[r].exp_cnt;
            end
        end
        wait_drain();
        check("random_total_beats", 64'(out_cnt), 64'(total));

        // Reset in the middle of payload, then a fresh packet.
        rand_mode = 1'b0;
        gaps = 1'b0;
        wait_drain();
        mon_ignore = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < B; b++) d[b*8 +: 8] = 8'($urandom);
            send_beat(d, kmask(B), 1'b0);
        end
        #2;
        reset = 1'b1;
        s_tvalid = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        check_zero("midrst_hold");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_tvalid", 64'(m_tvalid), 64'd0);
        exp_q.delete();
        mon_ignore = 1'b0;
        out_cnt = 0;
        send_packet(6, 32);
        wait_drain();
        check("post_rst_beats", 64'(out_cnt), 64'd7);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
